// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined execute-stage ALU.
// Holds the operation class and op codes (unchanged from the fixed ALU so
// decode is untouched), the controller state type and the flag bit indices.
package alu_pkg;

  // Operation classes (aluopselect)
  localparam logic [2:0] CLS_ARITH = 3'b001;
  localparam logic [2:0] CLS_EXT   = 3'b101;
  localparam logic [2:0] CLS_SEQ   = 3'b010;

  // CLS_ARITH ops
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_LUI = 3'b111;

  // CLS_EXT ops
  localparam logic [2:0] OP_SXB = 3'b000;
  localparam logic [2:0] OP_SXH = 3'b001;
  localparam logic [2:0] OP_ZXB = 3'b100;
  localparam logic [2:0] OP_ZXH = 3'b101;

  // CLS_SEQ ops
  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;

  typedef enum logic {IDLE, BUSY} state_t;

  // Bit positions inside flags = {carry, overflow, negative, zero}
  typedef enum logic [1:0] {
    FLG_ZERO  = 2'd0,
    FLG_NEG   = 2'd1,
    FLG_OVF   = 2'd2,
    FLG_CARRY = 2'd3
  } flag_idx_t;

  // True for the ops handled by the iterative unit; SEQ codes above SRA are
  // single-cycle pass-B.
  function automatic logic is_seq_op(input logic [2:0] sel, input logic [2:0] op);
    return (sel == CLS_SEQ) && (op <= OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: iterative datapath for MUL (shift-add, one multiplier bit per
// cycle) and SLL/SRL/SRA (one position per cycle).
// Ports:
//   clk, reset      clock, async active-high reset
//   start           load operands and begin iterating
//   op              CLS_SEQ op code (MUL/SLL/SRL/SRA)
//   a, b            operands (b is the multiplier for MUL)
//   shamt           shift amount
//   result          value to capture on the done cycle
//   done            high during the last iteration cycle
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic             active, nop_shift;
  logic [WIDTH-1:0] step;

  // acc is the product accumulator for MUL and the shifting value otherwise.
  always_comb begin
    step = acc;
    case (op_q)
      OP_MUL:  step = mplier[0] ? acc + mcand : acc;
      OP_SLL:  step = acc << 1;
      OP_SRL:  step = acc >> 1;
      OP_SRA:  step = $signed(acc) >>> 1;
      default: step = acc;
    endcase
    // A zero shift still takes one cycle but must return A untouched.
    result = nop_shift ? acc : step;
  end

  assign done = active && (cnt == CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      op_q      <= OP_MUL;
      active    <= 1'b0;
      nop_shift <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      op_q   <= op;
      mcand  <= a;
      mplier <= b;
      if (op == OP_MUL) begin
        acc       <= '0;
        cnt       <= CW'(WIDTH);
        nop_shift <= 1'b0;
      end else begin
        acc       <= a;
        cnt       <= (shamt == '0) ? CNT_ONE : {1'b0, shamt};
        nop_shift <= (shamt == '0);
      end
    end else if (active) begin
      acc    <= result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked execute-stage ALU with registered result and flags,
// persistent add-with-carry flag and an iterative MUL/shift unit.
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid / in_ready        operation handshake
//   aluopselect, aluoperation  op class / op within class
//   aluin1, aluin2             operands A, B
//   out_valid / out_ready      result handshake
//   aluout, flags              result and {carry, overflow, negative, zero}
//   busy                       multi-cycle op iterating
//
// state | meaning
// IDLE  | no work in flight; output register may hold a result
// BUSY  | MUL or shift iterating in alu_seq_unit
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluopselect,
  input  logic [2:0]       aluoperation,
  input  logic [WIDTH-1:0] aluin1,
  input  logic [WIDTH-1:0] aluin2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic             cflag;
  logic             accept, seq_start, seq_done;
  logic [WIDTH-1:0] seq_result;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH:0]   sum;
  logic             sc_c, sc_v, sc_upd_c, cin;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    logic [3:0] f;
    f            = '0;
    f[FLG_CARRY] = c;
    f[FLG_OVF]   = v;
    f[FLG_NEG]   = r[MSB];
    f[FLG_ZERO]  = (r == '0);
    return f;
  endfunction

  // Reset also gates in_ready so nothing is accepted while it is asserted.
  assign in_ready  = (state_q == IDLE) && (!out_valid || out_ready) && !reset;
  assign accept    = in_valid && in_ready;
  assign seq_start = accept && is_seq_op(aluopselect, aluoperation);
  assign busy      = (state_q == BUSY);
  assign cin       = (aluoperation == OP_ADC) && cflag;

  always_comb begin
    sc_res   = aluin2;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_upd_c = 1'b0;
    sum      = '0;
    case (aluopselect)
      CLS_ARITH: begin
        case (aluoperation)
          OP_ADD, OP_ADC: begin
            sum      = {1'b0, aluin1} + {1'b0, aluin2} + {{WIDTH{1'b0}}, cin};
            sc_res   = sum[MSB:0];
            sc_c     = sum[WIDTH];
            sc_v     = (aluin1[MSB] == aluin2[MSB]) && (sc_res[MSB] != aluin1[MSB]);
            sc_upd_c = 1'b1;
          end
          OP_SUB: begin
            // Top bit of the widened difference is the unsigned borrow.
            sum      = {1'b0, aluin1} - {1'b0, aluin2};
            sc_res   = sum[MSB:0];
            sc_c     = sum[WIDTH];
            sc_v     = (aluin1[MSB] != aluin2[MSB]) && (sc_res[MSB] != aluin1[MSB]);
            sc_upd_c = 1'b1;
          end
          OP_NOT:  sc_res = ~aluin2;
          OP_AND:  sc_res = aluin1 & aluin2;
          OP_OR:   sc_res = aluin1 | aluin2;
          OP_XOR:  sc_res = aluin1 ^ aluin2;
          OP_LUI:  sc_res = {aluin2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
          default: sc_res = aluin2;
        endcase
      end
      CLS_EXT: begin
        case (aluoperation)
          OP_SXB:  sc_res = {{(WIDTH-8){aluin2[7]}}, aluin2[7:0]};
          OP_ZXB:  sc_res = {{(WIDTH-8){1'b0}}, aluin2[7:0]};
          OP_SXH:  sc_res = {{(WIDTH-16){aluin2[15]}}, aluin2[15:0]};
          OP_ZXH:  sc_res = {{(WIDTH-16){1'b0}}, aluin2[15:0]};
          default: sc_res = aluin2;
        endcase
      end
      default: sc_res = aluin2;
    endcase
  end

  alu_seq_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (seq_start),
    .op     (aluoperation),
    .a      (aluin1),
    .b      (aluin2),
    .shamt  (aluin2[SHW-1:0]),
    .result (seq_result),
    .done   (seq_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (seq_start) state_d = BUSY;
      BUSY:    if (seq_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A multi-cycle op is only accepted when the output register drains on the
  // same edge, so the output register is always empty when seq_done fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      aluout    <= '0;
      flags     <= '0;
      cflag     <= 1'b0;
    end else begin
      if (accept && !seq_start) begin
        out_valid <= 1'b1;
        aluout    <= sc_res;
        flags     <= mk_flags(sc_res, sc_c, sc_v);
        if (sc_upd_c) cflag <= sc_c;
      end else if (seq_done) begin
        out_valid <= 1'b1;
        aluout    <= seq_result;
        flags     <= mk_flags(seq_result, 1'b0, 1'b0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
